// File: rtl/tod_pkg.sv
// tod_pkg: field limits, cursor codes and wrap helpers shared by the time-of-day counter
package tod_pkg;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [2:0] CUR_SEC = 3'b001;
  localparam logic [2:0] CUR_MIN = 3'b010;
  localparam logic [2:0] CUR_HOUR = 3'b100;
  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } todTime;
  // compare-before-step keeps every field inside 6 bits
  function automatic logic [5:0] incWrap(input logic [5:0] v, input logic [5:0] top);
    return v == top ? 6'd0 : v + 6'd1;
  endfunction
  function automatic logic [5:0] decWrap(input logic [5:0] v, input logic [5:0] top);
    return v == 6'd0 ? top : v - 6'd1;
  endfunction
  function automatic logic [5:0] stepField(input logic [5:0] v, input logic [5:0] top,
                                           input logic en, input logic isUp);
    return !en ? v : isUp ? incWrap(v, top) : decWrap(v, top);
  endfunction
  function automatic logic [5:0] to_12h(input logic [5:0] h);
    return h == 6'd0 ? 6'd12 : h > 6'd12 ? h - 6'd12 : h;
  endfunction
endpackage

// File: rtl/tod_prescaler.sv
// tod_prescaler: divides clk down to a one-cycle tick every CLK_HZ cycles while running
module tod_prescaler #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);
  logic [W-1:0] count;
  assign tick = run && count == TERM;
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (run) count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: h/m/s keeper with field adjust, validated load, deferred ticks,
// alarm match and 12/24-hour display formatting
module time_of_day_counter #(
  parameter int CLK_HZ = 100000000,
  parameter bit ADJ_CARRY = 1'b0,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode24,
  input  logic [2:0] cursor,
  input  logic       up,
  input  logic       down,
  input  logic       load,
  input  logic [5:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  input  logic       alarm_set,
  input  logic       alarm_arm,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       pm,
  output logic       sec_pulse,
  output logic       load_err,
  output logic       alarm_hit
);
  import tod_pkg::*;
  todTime cur, tickT, adjT;
  logic tick, tickPending, loadOk, adjValid, busy, discard, applyTick;
  logic minStep, hourStep, secPulse, loadErr;
  tod_prescaler #(.CLK_HZ(CLK_HZ)) prescaler (
    .clk(clk),
    .reset(reset),
    .run(run),
    .clear(discard),
    .tick(tick)
  );
  assign loadOk = load_h <= HOUR_MAX && load_m <= MIN_MAX && load_s <= SEC_MAX;
  assign adjValid = (up ^ down) && $onehot(cursor);
  assign busy = load || adjValid;
  // restarting the prescaler makes any owed tick stale
  assign discard = load ? loadOk : adjValid && cursor == CUR_SEC;
  assign applyTick = !busy && (tick || tickPending);
  always_comb begin
    tickT.s = incWrap(cur.s, SEC_MAX);
    tickT.m = cur.s == SEC_MAX ? incWrap(cur.m, MIN_MAX) : cur.m;
    tickT.h = cur.s == SEC_MAX && cur.m == MIN_MAX ? incWrap(cur.h, HOUR_MAX) : cur.h;
  end
  always_comb begin
    minStep = cursor == CUR_MIN || (ADJ_CARRY && cursor == CUR_SEC && cur.s == (up ? SEC_MAX : 6'd0));
    hourStep = cursor == CUR_HOUR || (ADJ_CARRY && minStep && cur.m == (up ? MIN_MAX : 6'd0));
    adjT.s = stepField(cur.s, SEC_MAX, cursor == CUR_SEC, up);
    adjT.m = stepField(cur.m, MIN_MAX, minStep, up);
    adjT.h = stepField(cur.h, HOUR_MAX, hourStep, up);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      tickPending <= 1'b0;
      secPulse <= 1'b0;
      loadErr <= 1'b0;
    end else begin
      secPulse <= applyTick;
      loadErr <= load && !loadOk;
      tickPending <= busy ? !discard && (tick || tickPending) : tick && tickPending;
      if (load) begin
        if (loadOk) cur <= {load_h, load_m, load_s};
      end else if (adjValid) cur <= adjT;
      else if (applyTick) cur <= tickT;
    end
  end
  generate
    if (ALARM_EN) begin : g_alarm
      logic [5:0] alarmH, alarmM;
      logic hit;
      always_ff @(posedge clk) begin
        if (reset) begin
          alarmH <= '0;
          alarmM <= '0;
          hit <= 1'b0;
        end else begin
          if (alarm_set) begin
            alarmH <= load_h;
            alarmM <= load_m;
          end
          hit <= applyTick && alarm_arm && tickT == {alarmH, alarmM, 6'd0};
        end
      end
      assign alarm_hit = hit;
    end else begin : g_noAlarm
      assign alarm_hit = 1'b0;
    end
  endgenerate
  assign hour = mode24 ? cur.h : to_12h(cur.h);
  assign minute = cur.m;
  assign second = cur.s;
  assign pm = cur.h >= 6'd12;
  assign sec_pulse = secPulse;
  assign load_err = loadErr;
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed + random stimulus on ADJ_CARRY=0/1 instances,
// checked against a seconds-of-day reference model
module tb_time_of_day_counter;
  localparam int HZ = 10;
  localparam int DAY = 86400;
  logic clk = 1'b0;
  logic reset, run, mode24, up, down, load, alarm_set, alarm_arm;
  logic [2:0] cursor;
  logic [5:0] load_h, load_m, load_s;
  logic [5:0] hourO [2];
  logic [5:0] minuteO [2];
  logic [5:0] secondO [2];
  logic pmO [2];
  logic secPulseO [2];
  logic loadErrO [2];
  logic alarmHitO [2];
  int checks = 0, failures = 0;
  int tod [2];
  int presc, alarmH, alarmM, secSeen, gap;
  int hitSeen [2];
  bit owed, expPulse, expErr;
  bit expHit [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    time_of_day_counter #(.CLK_HZ(HZ), .ADJ_CARRY(g == 1), .ALARM_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .run(run), .mode24(mode24), .cursor(cursor),
      .up(up), .down(down), .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
      .alarm_set(alarm_set), .alarm_arm(alarm_arm),
      .hour(hourO[g]), .minute(minuteO[g]), .second(secondO[g]), .pm(pmO[g]),
      .sec_pulse(secPulseO[g]), .load_err(loadErrO[g]), .alarm_hit(alarmHitO[g])
    );
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int adjTod(int t, logic [2:0] c, bit isUp, bit carry);
    int d = isUp ? 1 : -1;
    int hh = t / 3600;
    int mm = t / 60 % 60;
    int ss = t % 60;
    if (carry || c == 3'b100) return (t + d * (c == 3'b001 ? 1 : c == 3'b010 ? 60 : 3600) + DAY) % DAY;
    if (c == 3'b001) ss = (ss + d + 60) % 60;
    else mm = (mm + d + 60) % 60;
    return hh * 3600 + mm * 60 + ss;
  endfunction

  function automatic int disp(int hh, bit m24);
    return m24 ? hh : hh == 0 ? 12 : hh > 12 ? hh - 12 : hh;
  endfunction

  task automatic cyc();
    bit tick, okLoad, adjOk, busy, restart, apply;
    @(posedge clk);
    if (reset) begin
      tod = '{0, 0};
      presc = 0;
      owed = 0;
      alarmH = 0;
      alarmM = 0;
      expPulse = 0;
      expErr = 0;
      expHit = '{0, 0};
    end else begin
      tick = run && presc == HZ - 1;
      okLoad = load_h < 24 && load_m < 60 && load_s < 60;
      adjOk = (up != down) && cursor inside {3'b001, 3'b010, 3'b100};
      busy = load || adjOk;
      restart = load ? okLoad : adjOk && cursor == 3'b001;
      apply = !busy && (tick || owed);
      presc = (restart || tick) ? 0 : presc + int'(run);
      // a tick landing on a load/adjust is owed unless the prescaler restarted
      if (busy) owed = !restart && (owed || tick);
      else owed = owed && tick;
      expPulse = apply;
      expErr = load && !okLoad;
      for (int i = 0; i < 2; i++) begin
        if (load) begin
          if (okLoad) tod[i] = load_h * 3600 + load_m * 60 + load_s;
        end else if (adjOk) tod[i] = adjTod(tod[i], cursor, up, i == 1);
        else if (apply) tod[i] = (tod[i] + 1) % DAY;
        expHit[i] = apply && alarm_arm && alarmH < 24 && alarmM < 60 && tod[i] == alarmH * 3600 + alarmM * 60;
      end
      if (alarm_set) begin
        alarmH = load_h;
        alarmM = load_m;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checkVal($sformatf("hour%0d", i), hourO[i], disp(tod[i] / 3600, mode24));
      checkVal($sformatf("minute%0d", i), minuteO[i], tod[i] / 60 % 60);
      checkVal($sformatf("second%0d", i), secondO[i], tod[i] % 60);
      checkVal($sformatf("pm%0d", i), pmO[i], tod[i] >= 12 * 3600);
      checkVal($sformatf("sec_pulse%0d", i), secPulseO[i], expPulse);
      checkVal($sformatf("load_err%0d", i), loadErrO[i], expErr);
      checkVal($sformatf("alarm_hit%0d", i), alarmHitO[i], expHit[i]);
      hitSeen[i] += int'(alarmHitO[i]);
    end
    secSeen += int'(secPulseO[0]);
    up = 0;
    down = 0;
    load = 0;
    alarm_set = 0;
  endtask

  task automatic doLoad(input int hh, input int mm, input int ss);
    load = 1;
    load_h = 6'(hh);
    load_m = 6'(mm);
    load_s = 6'(ss);
    cyc();
  endtask

  initial begin
    int t;
    reset = 1; run = 0; mode24 = 1; cursor = 3'b001; up = 0; down = 0; load = 0;
    load_h = 0; load_m = 0; load_s = 0; alarm_set = 0; alarm_arm = 0;
    secSeen = 0; hitSeen = '{0, 0};
    cyc();
    up = 1; load = 1; load_h = 6'd5; run = 1;
    cyc();
    checkVal("rst_hour", hourO[0], 0);
    checkVal("rst_sec", secondO[0], 0);
    checkVal("rst_pulse", secPulseO[0], 0);
    reset = 0;
    mode24 = 0;
    doLoad(23, 59, 58);
    checkVal("t1_pm_before", pmO[0], 1);
    secSeen = 0;
    repeat (20) cyc();
    checkVal("t1_pulses", secSeen, 2);
    checkVal("t1_hour12", hourO[0], 12);
    checkVal("t1_pm_after", pmO[0], 0);
    doLoad(24, 0, 0);
    checkVal("t2_err", loadErrO[0], 1);
    mode24 = 1;
    doLoad(10, 0, 0);
    cursor = 3'b010; down = 1;
    cyc();
    checkVal("t3_hour_c0", hourO[0], 10);
    checkVal("t3_min_c0", minuteO[0], 59);
    checkVal("t3_hour_c1", hourO[1], 9);
    checkVal("t3_min_c1", minuteO[1], 59);
    doLoad(12, 0, 0);
    repeat (9) cyc();
    cursor = 3'b010; up = 1; secSeen = 0;
    cyc();
    checkVal("t4_min", minuteO[0], 1);
    checkVal("t4_sec", secondO[0], 0);
    cyc();
    checkVal("t4_sec_next", secondO[0], 1);
    repeat (3) cyc();
    checkVal("t4_pulses", secSeen, 1);
    doLoad(12, 0, 0);
    repeat (9) cyc();
    cursor = 3'b001; up = 1;
    cyc();
    secSeen = 0; gap = 0;
    while (secSeen == 0 && gap < 30) begin
      cyc();
      gap++;
    end
    checkVal("t5_gap", gap, 10);
    load_h = 6'd7; load_m = 6'd30; alarm_set = 1;
    cyc();
    alarm_arm = 1;
    doLoad(7, 29, 59);
    hitSeen = '{0, 0};
    repeat (12) cyc();
    checkVal("t6_hit_c0", hitSeen[0], 1);
    checkVal("t6_hit_c1", hitSeen[1], 1);
    doLoad(7, 30, 0);
    hitSeen = '{0, 0};
    repeat (12) cyc();
    checkVal("t6_nohit", hitSeen[0], 0);
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 499) == 0;
      run = $urandom_range(0, 9) != 0;
      mode24 = 1'($urandom_range(0, 1));
      alarm_arm = $urandom_range(0, 3) != 0;
      cursor = $urandom_range(0, 9) < 8 ? 3'b001 << $urandom_range(0, 2) : 3'($urandom_range(0, 7));
      up = $urandom_range(0, 9) == 0;
      down = $urandom_range(0, 9) == 0;
      load = $urandom_range(0, 19) == 0;
      load_h = 6'($urandom_range(0, 25));
      load_m = 6'($urandom_range(0, 61));
      load_s = 6'($urandom_range(0, 61));
      if (load && alarmH < 24 && alarmM < 60 && $urandom_range(0, 1) == 1) begin
        t = (alarmH * 3600 + alarmM * 60 - int'($urandom_range(1, 5)) + DAY) % DAY;
        load_h = 6'(t / 3600);
        load_m = 6'(t / 60 % 60);
        load_s = 6'(t % 60);
      end
      alarm_set = $urandom_range(0, 29) == 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Parametrised time-of-day keeper for the Nixie clock: hours/minutes/seconds state, per-field up/down adjust, bulk load, run/pause, alarm match and 12/24-hour display formatting.
- Sits between the input handler (cursor, up/down pulses) and the display/digit-multiplex logic.
- Adds over the previous clock storage:
  - tick deferral on collisions
  - validated bulk load
  - optional carry-on-adjust
  - PM flag
  - alarm

Parameters:
- CLK_HZ, 100000000, input clock frequency; prescaler terminal count is CLK_HZ-1.
- ADJ_CARRY, 0, 0 = adjust wraps within its field only; 1 = adjust carries/borrows into the next field up (hour still wraps 23↔0).
- ALARM_EN, 1, 0 = alarm logic removed and alarm_hit tied 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  1 = time advances; 0 = paused, prescaler held
- mode24  in  1  1 = 24-hour display, 0 = 12-hour display
- cursor  in  3  one-hot field select: 001 = sec, 010 = min, 100 = hour
- up  in  1  one-cycle increment pulse for the selected field
- down  in  1  one-cycle decrement pulse for the selected field
- load  in  1  one-cycle bulk load of load_h/load_m/load_s
- load_h  in  6  hour to load, 0..23
- load_m  in  6  minute to load, 0..59
- load_s  in  6  second to load, 0..59
- alarm_set  in  1  captures the current load_h/load_m as the alarm time
- alarm_arm  in  1  alarm enable
- hour  out  6  display hour
- minute  out  6  current minute
- second  out  6  current second
- pm  out  1  1 when internal hour is 12..23, valid in both modes
- sec_pulse  out  1  one-cycle pulse on each applied seconds tick
- load_err  out  1  one-cycle pulse when a load is rejected
- alarm_hit  out  1  one-cycle pulse on alarm match

Behaviour:
- Reset:
  - h/m/s = 0, prescaler = 0, tick_pending = 0.
  - Alarm = 00:00, stored disarmed-independent.
  - All pulse outputs 0.
  - Reset overrides all other inputs in the same cycle.
- Prescaler:
  - Counts 0..CLK_HZ-1 while run = 1.
  - Raises tick when at CLK_HZ-1, then wraps to 0.
  - Holds its value while run = 0.
- Priority per cycle: reset > load > adjust > tick.
- Tick application:
  - Advances seconds; carries 59→0 into minutes, minutes 59→0 into hours, hours 23→0.
  - sec_pulse asserts in the cycle after the state update, aligned with the new value.
- Load:
  - Accepted only if load_h ≤ 23, load_m ≤ 59 and load_s ≤ 59; all three fields are written at once.
  - Otherwise state is unchanged and load_err pulses for 1 cycle.
  - A successful load clears the prescaler to 0, so the next tick comes a full CLK_HZ cycles later.
- Adjust:
  - Acts only when exactly one of up/down is high and cursor is exactly one-hot; otherwise ignored.
  - Wraps: sec/min 59↔0, hour 23↔0.
  - With ADJ_CARRY = 1, a wrapping step propagates into the next field up.
  - A seconds adjust clears the prescaler.
  - Minute or hour adjusts leave the prescaler running.
- Collision: if tick coincides with load or a valid adjust, the tick is not lost.
  - tick_pending is set and the tick is applied on the next cycle free of load/adjust.
  - If the collision is with a load or a seconds adjust, the pending tick is discarded, because the prescaler restarted.
  - tick_pending never accumulates more than 1.
- Display conversion:
  - Combinational from the state registers (zero latency).
  - 12-hour mode: 0→12, 1..12→same, 13..23→h-12.
  - minute and second pass through unchanged.
- Alarm (ALARM_EN = 1):
  - alarm_set stores load_h/load_m with no range check; out-of-range values can never match.
  - alarm_hit pulses once when a tick (including a deferred tick) moves the time to alarm_h:alarm_m:00 with alarm_arm = 1.
  - Load or adjust landing on the alarm time does not fire it.
- Arithmetic: all fields are 6-bit unsigned. Compare before increment so 6-bit overflow never occurs.

Decomposition:
- Package tod_pkg:
  - SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23
  - cursor encodings CUR_SEC, CUR_MIN, CUR_HOUR
  - function to_12h
- Sub-module tod_prescaler:
  - Parameters: CLK_HZ.
  - Ports: clk, reset, run, clear, tick.
  - Counter width $clog2(CLK_HZ).

Test Plan (CLK_HZ = 10):
- Reset, run = 1, load 23:59:58, wait 20 cycles → 2 sec_pulses, time 00:00:00, pm goes 1→0, mode24 = 0 shows hour 12.
- load_h = 24, load_m = 0, load_s = 0 → load_err pulse, state unchanged.
- Load 10:00:00, cursor = 010, down ×1 → 10:59:00 with ADJ_CARRY = 0; 09:59:00 with ADJ_CARRY = 1.
- Minute up pulse exactly on the prescaler terminal cycle → minute +1 that cycle, second +1 on the following cycle, one sec_pulse total.
- Seconds up on the terminal cycle → pending tick discarded; next sec_pulse exactly 10 cycles later.
- alarm_set with 07:30, arm, load 07:29:59 → alarm_hit on the rollover to 07:30:00; repeat the load at 07:30:00 → no hit.
